// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the unified-memory arbiter and any other
// arbiter built on arb_pick (e.g. a future cache-fill arbiter).
//   state_t   : arbiter FSM states
//   ARB_FIXED : lowest-index-wins arbitration
//   ARB_RR    : round-robin arbitration
//   slice_lo  : low bit offset of port idx inside a packed per-port bus
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Timeout counter width; wide enough for the largest allowed TIMEOUT (255).
  localparam int CNT_W = 8;

  // Port idx of a packed bus lives at [slice_lo(idx, width) +: width].
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Purely combinational winner selection over an eligibility vector.
//   eligible  : one bit per requester that may be granted this cycle
//   ptr       : round-robin start index (ignored in fixed mode)
//   mode      : 0 = fixed priority (lowest index), 1 = round robin
//   winner    : selected index (0 when nothing is eligible)
//   any_valid : at least one requester is eligible
// ---------------------------------------------------------------------------
module arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 mode,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_valid
);

  // Index reached by stepping ofs places from base, wrapping modulo NUM_PORTS.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int              ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return IDX_W'(sum);
  endfunction

  // Scan from the far end toward the preferred position so that the last
  // hit (the closest to index 0 / to ptr) is the one that sticks.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    winner    = '0;
    any_valid = |eligible;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (mode) begin
        if (eligible[rr_idx(ptr, k)]) winner = rr_idx(ptr, k);
      end else begin
        if (eligible[k]) winner = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n
// Shares one multi-cycle unified memory among NUM_PORTS requesters.
// One transaction is outstanding at a time: IDLE grants, BUSY waits for
// mem_rvalid (or a timeout), RESP presents a one-cycle response pulse.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_valid   : per-port request, held until that port's resp_valid
//   req_write   : per-port 1 = write, 0 = read
//   req_addr    : packed per-port addresses  (port i at [i*ADDR_W +: ADDR_W])
//   req_wdata   : packed per-port write data (port i at [i*DATA_W +: DATA_W])
//   req_stall   : req_valid & ~resp_valid, pipeline freeze per port
//   resp_valid  : one-cycle completion pulse, one-hot or zero
//   resp_rdata  : read data, valid with resp_valid (0 on timeout)
//   resp_err    : pulses with resp_valid when the transaction timed out
//   mem_en      : one-cycle command strobe, mem_wr qualifies it
//   mem_addr    : command address, held through BUSY
//   mem_wdata   : command write data, held through BUSY
//   mem_rdata   : memory data, sampled with mem_rvalid
//   mem_rvalid  : memory completion for reads and writes
// ---------------------------------------------------------------------------
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_stall,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_err,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_rvalid
);

  localparam int                   IDX_W   = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] PORT0   = NUM_PORTS'(1);
  localparam logic [IDX_W-1:0]     LAST    = IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(TIMEOUT);
  localparam logic                 RR_MODE = (ARB_MODE == ARB_RR);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  grant_idx;   // port owning the outstanding transaction
  logic [IDX_W-1:0]  rr_ptr;      // round-robin search start
  logic [CNT_W-1:0]  to_cnt;      // BUSY cycles elapsed since mem_en

  logic [NUM_PORTS-1:0] eligible;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic do_grant;
  logic do_resp;
  logic do_timeout;

  // A port whose response is on the wire this cycle must not be re-granted
  // off the same, not-yet-dropped req_valid.
  assign eligible  = req_valid & ~resp_valid;
  assign req_stall = req_valid & ~resp_valid;

  arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .mode      (RR_MODE),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_resp    = 1'b0;
    do_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        // mem_rvalid is deliberately not looked at here: a stray or late
        // completion with nothing outstanding is dropped.
        if (pick_any) begin
          do_grant  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A completion arriving in the same cycle as the timeout wins.
        if (mem_rvalid) begin
          do_resp   = 1'b1;
          state_nxt = RESP;
        end else if (to_cnt == TO_LAST) begin
          do_timeout = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Command latch, timeout counter, round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx <= '0;
      rr_ptr    <= '0;
      to_cnt    <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= do_grant;
      mem_wr <= do_grant & req_write[pick_idx];
      if (do_grant) begin
        grant_idx <= pick_idx;
        mem_addr  <= req_addr[slice_lo(int'(pick_idx), ADDR_W) +: ADDR_W];
        mem_wdata <= req_wdata[slice_lo(int'(pick_idx), DATA_W) +: DATA_W];
        to_cnt    <= '0;
        if (RR_MODE) rr_ptr <= (pick_idx == LAST) ? '0 : pick_idx + IDX_W'(1);
      end else if (state == BUSY) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response registers: one-cycle pulse, data held until the next response
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      if (do_resp) begin
        resp_valid <= PORT0 << grant_idx;
        resp_rdata <= mem_rdata;
      end else if (do_timeout) begin
        resp_valid <= PORT0 << grant_idx;
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_n
// Two instances: dut2 (2 ports, fixed priority) and dut4 (4 ports, round
// robin), both TIMEOUT = 15. Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- dut2: 2 ports, fixed priority -------------------------
  logic        rst2_n;
  logic [1:0]  rv2, wr2, stall2, resp2;
  logic [31:0] addr2, wdata2;
  logic [15:0] rdata2, maddr2, mwdata2, mrd2;
  logic        err2, en2, mw2, mrv2;

  mem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .ARB_MODE(0), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(rv2), .req_write(wr2), .req_addr(addr2),
    .req_wdata(wdata2), .req_stall(stall2), .resp_valid(resp2), .resp_rdata(rdata2),
    .resp_err(err2), .mem_en(en2), .mem_wr(mw2), .mem_addr(maddr2), .mem_wdata(mwdata2),
    .mem_rdata(mrd2), .mem_rvalid(mrv2));

  // ---------------- dut4: 4 ports, round robin ----------------------------
  logic        rst4_n;
  logic [3:0]  rv4, wr4, stall4, resp4;
  logic [63:0] addr4, wdata4;
  logic [15:0] rdata4, maddr4, mwdata4, mrd4;
  logic        err4, en4, mw4, mrv4;

  mem_arbiter_n #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(16), .ARB_MODE(1), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req_valid(rv4), .req_write(wr4), .req_addr(addr4),
    .req_wdata(wdata4), .req_stall(stall4), .resp_valid(resp4), .resp_rdata(rdata4),
    .resp_err(err4), .mem_en(en4), .mem_wr(mw4), .mem_addr(maddr4), .mem_wdata(mwdata4),
    .mem_rdata(mrd4), .mem_rvalid(mrv4));

  // One row per clock cycle of dut2.
  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  wr;
    logic        mrv;
    logic [15:0] mrd;
    logic        en;
    logic        mwr;
    logic [1:0]  resp;
    logic        err;
    logic [1:0]  stall;
    logic        chk_rd;
    logic [15:0] rd;
    logic        chk_cmd;
    logic [15:0] addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vecs [15];

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  // Request from port 0 of dut2 that is never answered, or answered exactly
  // in the last BUSY cycle before the timeout would fire.
  task automatic timeout_run(input logic answer_at_edge);
    for (int c = 0; c <= 18; c++) begin
      cyc_start();
      rv2  = (c <= 17) ? 2'b01 : 2'b00;
      mrv2 = answer_at_edge && (c == 16);
      mrd2 = 16'h4242;
      @(negedge clk);
      check($sformatf("to%0d_en_c%0d", answer_at_edge, c), 32'(en2), 32'(c == 1));
      check($sformatf("to%0d_resp_c%0d", answer_at_edge, c), 32'(resp2), (c == 17) ? 32'h1 : 32'h0);
      check($sformatf("to%0d_err_c%0d", answer_at_edge, c), 32'(err2), 32'(c == 17 && !answer_at_edge));
      if (c == 17)
        check($sformatf("to%0d_rdata", answer_at_edge), 32'(rdata2), answer_at_edge ? 32'h4242 : 32'h0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          ng;
    int          g;
    int          last_g;
    logic        pend;
    int          exp_order [5];

    // ---------------- reset state ----------------
    rst2_n = 1'b0; rst4_n = 1'b0;
    rv2 = '0; wr2 = '0; mrv2 = 1'b0; mrd2 = '0;
    addr2  = {16'h0010, 16'h00FF};
    wdata2 = {16'h7777, 16'h1234};
    rv4 = '0; wr4 = '0; mrv4 = 1'b0; mrd4 = '0;
    addr4  = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    wdata4 = {16'h0203, 16'h0202, 16'h0201, 16'h0200};
    repeat (3) @(negedge clk);
    check("rst2_resp",  32'(resp2),   32'h0);
    check("rst2_err",   32'(err2),    32'h0);
    check("rst2_en",    32'(en2),     32'h0);
    check("rst2_wr",    32'(mw2),     32'h0);
    check("rst2_addr",  32'(maddr2),  32'h0);
    check("rst2_wdata", 32'(mwdata2), 32'h0);
    check("rst2_rdata", 32'(rdata2),  32'h0);
    check("rst4_resp",  32'(resp4),   32'h0);
    check("rst4_en",    32'(en4),     32'h0);
    check("rst4_addr",  32'(maddr4),  32'h0);
    rst2_n = 1'b1; rst4_n = 1'b1;

    // ---------------- table: L=4 read from port 1, L=1 write from port 0 ----
    //           rv     wr     mrv  mrd       en mwr resp  err stall  chk_rd rd        chk_cmd addr      wdata
    vecs[0]  = '{2'b10, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[1]  = '{2'b10, 2'b00, 0, 16'h0000, 1, 0, 2'b00, 0, 2'b10, 0, 16'h0000, 1, 16'h0010, 16'h7777};
    vecs[2]  = '{2'b10, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b10, 0, 16'h0000, 1, 16'h0010, 16'h7777};
    vecs[3]  = '{2'b10, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[4]  = '{2'b10, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[5]  = '{2'b10, 2'b00, 1, 16'hBEEF, 0, 0, 2'b00, 0, 2'b10, 0, 16'h0000, 1, 16'h0010, 16'h7777};
    vecs[6]  = '{2'b10, 2'b00, 0, 16'h0000, 0, 0, 2'b10, 0, 2'b00, 1, 16'hBEEF, 0, 16'h0000, 16'h0000};
    vecs[7]  = '{2'b00, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[8]  = '{2'b01, 2'b01, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b01, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[9]  = '{2'b01, 2'b01, 0, 16'h0000, 1, 1, 2'b00, 0, 2'b01, 0, 16'h0000, 1, 16'h00FF, 16'h1234};
    vecs[10] = '{2'b01, 2'b01, 1, 16'h5555, 0, 0, 2'b00, 0, 2'b01, 0, 16'h0000, 1, 16'h00FF, 16'h1234};
    vecs[11] = '{2'b01, 2'b01, 0, 16'h0000, 0, 0, 2'b01, 0, 2'b00, 1, 16'h5555, 0, 16'h0000, 16'h0000};
    vecs[12] = '{2'b00, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[13] = '{2'b00, 2'b00, 1, 16'hDEAD, 0, 0, 2'b00, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[14] = '{2'b00, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 16'h0000};

    for (int i = 0; i < 15; i++) begin
      cyc_start();
      rv2 = vecs[i].rv; wr2 = vecs[i].wr; mrv2 = vecs[i].mrv; mrd2 = vecs[i].mrd;
      @(negedge clk);
      check($sformatf("vec%0d_en", i),    32'(en2),    32'(vecs[i].en));
      check($sformatf("vec%0d_wr", i),    32'(mw2),    32'(vecs[i].mwr));
      check($sformatf("vec%0d_resp", i),  32'(resp2),  32'(vecs[i].resp));
      check($sformatf("vec%0d_err", i),   32'(err2),   32'(vecs[i].err));
      check($sformatf("vec%0d_stall", i), 32'(stall2), 32'(vecs[i].stall));
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), 32'(rdata2), 32'(vecs[i].rd));
      if (vecs[i].chk_cmd) begin
        check($sformatf("vec%0d_addr", i),  32'(maddr2),  32'(vecs[i].addr));
        check($sformatf("vec%0d_wdata", i), 32'(mwdata2), 32'(vecs[i].wdata));
      end
    end

    // ---------------- both ports at once, fixed priority ----------------
    for (int c = 0; c <= 14; c++) begin
      cyc_start();
      rv2  = (c < 7) ? 2'b11 : (c < 14) ? 2'b10 : 2'b00;
      wr2  = 2'b00;
      mrv2 = (c == 5) || (c == 12);
      mrd2 = (c == 5) ? 16'hAAAA : 16'hBBBB;
      @(negedge clk);
      check($sformatf("both_en_c%0d", c), 32'(en2), 32'((c == 1) || (c == 8)));
      check($sformatf("both_resp_c%0d", c), 32'(resp2),
            (c == 6) ? 32'h1 : (c == 13) ? 32'h2 : 32'h0);
      if (c == 1)  check("both_addr_p0", 32'(maddr2), 32'h00FF);
      if (c == 8)  check("both_addr_p1", 32'(maddr2), 32'h0010);
      if (c == 6)  check("both_rdata_p0", 32'(rdata2), 32'hAAAA);
      if (c == 13) check("both_rdata_p1", 32'(rdata2), 32'hBBBB);
    end

    // ---------------- timeout, then completion on the timeout cycle -------
    timeout_run(1'b0);
    timeout_run(1'b1);

    // ---------------- round robin, all four ports requesting ----------------
    exp_order = '{0, 1, 2, 3, 0};
    ng     = 0;
    last_g = -1;
    pend   = 1'b0;
    rv4    = 4'b1111;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      cyc_start();
      mrv4 = pend;
      mrd4 = 16'hC000 + 16'(c);
      pend = 1'b0;
      @(negedge clk);
      if (resp4 != 4'b0000)
        check("rr_resp_port", 32'(resp4), 32'(4'b0001 << last_g));
      if (en4) begin
        g = int'(maddr4) - 'h100;
        check($sformatf("rr_grant%0d", ng), 32'(g), 32'(exp_order[ng]));
        if (ng > 0) check($sformatf("rr_not_repeat%0d", ng), 32'(g != last_g), 32'h1);
        last_g = g;
        ng++;
        pend = 1'b1;
      end
    end
    check("rr_grant_count", 32'(ng), 32'd5);

    // ---------------- reset during BUSY, then a late mem_rvalid -------------
    cyc_start();
    mrv4 = 1'b0;
    rv4  = 4'b0000;
    #2 rst4_n = 1'b0;
    #1;
    check("mid_rst_resp",  32'(resp4),   32'h0);
    check("mid_rst_err",   32'(err4),    32'h0);
    check("mid_rst_en",    32'(en4),     32'h0);
    check("mid_rst_wr",    32'(mw4),     32'h0);
    check("mid_rst_addr",  32'(maddr4),  32'h0);
    check("mid_rst_wdata", 32'(mwdata4), 32'h0);
    check("mid_rst_rdata", 32'(rdata4),  32'h0);
    check("mid_rst_stall", 32'(stall4),  32'h0);
    @(negedge clk);
    rst4_n = 1'b1;
    cyc_start();
    mrv4 = 1'b1;
    mrd4 = 16'hFACE;
    @(negedge clk);
    check("late_rv_resp0", 32'(resp4), 32'h0);
    cyc_start();
    mrv4 = 1'b0;
    @(negedge clk);
    check("late_rv_resp1", 32'(resp4), 32'h0);
    check("late_rv_en",    32'(en4),   32'h0);

    // Ports 0 and 2 request: a pointer back at 0 picks port 0.
    cyc_start();
    rv4 = 4'b0101;
    @(negedge clk);
    check("post_rst_stall", 32'(stall4), 32'h5);
    cyc_start();
    @(negedge clk);
    check("post_rst_en",   32'(en4),    32'h1);
    check("post_rst_addr", 32'(maddr4), 32'h0100);
    cyc_start();
    mrv4 = 1'b1;
    mrd4 = 16'h0ACE;
    @(negedge clk);
    cyc_start();
    mrv4 = 1'b0;
    @(negedge clk);
    check("post_rst_resp",  32'(resp4),  32'h1);
    check("post_rst_rdata", 32'(rdata4), 32'h0ACE);
    cyc_start();
    rv4 = 4'b0000;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
